wide_op_seq: RTL

WIDE_OP_SEQ -- requirements
Module: wide_op_seq

---
 rtl/wide_op_seq.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wide_op_seq.sv
// wide_op_seq -- sequences a 16-bit operation over an external 8-bit
// combinational ALU, low byte first, then high byte.
//
// Optional feature: define WIDE_OP_OVF_EN to add the OVF output
// (signed overflow of ADD16). Without it the port and its logic are absent.
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   START        in   request an operation (sampled only in IDLE)
//   CMD[1:0]     in   00 ADD16, 01 SLL16, 10 XOR16, 11 NOT16
//   OPA_IN[15:0] in   operand A
//   OPB_IN[15:0] in   operand B (unused by SLL16 / NOT16)
//   BUSY         out  high while the LO and HI halves are being processed
//   DONE         out  one-cycle pulse, RESULT/CARRY valid
//   RESULT[15:0] out  last completed result
//   CARRY        out  carry / shift-out of last completed operation
//   ALU_OP[3:0]  out  opcode to the 8-bit ALU
//   ALU_A/B[7:0] out  ALU data inputs
//   ALU_SC       out  ALU shift/carry-in
//   ALU_OUT[7:0] in   ALU result (combinational, same cycle)
//   ALU_SC_OUT   in   ALU shift/carry-out
//   OVF          out  signed overflow of ADD16 (WIDE_OP_OVF_EN only)

package wide_op_pkg;
    localparam logic [3:0] kNOP  = 4'h0;
    localparam logic [3:0] kADDL = 4'h1;  // A + B + SC, SC_OUT = carry
    localparam logic [3:0] kSLG  = 4'h2;  // B << 1 fill 0, SC_OUT = B[7]
    localparam logic [3:0] kSLO  = 4'h3;  // B << 1 fill SC, SC_OUT = B[7]
    localparam logic [3:0] kXOR  = 4'h4;  // A ^ B
    localparam logic [3:0] kNOT  = 4'h5;  // ~B

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SLL = 2'b01;
    localparam logic [1:0] CMD_XOR = 2'b10;
    localparam logic [1:0] CMD_NOT = 2'b11;
endpackage

// state  | meaning
// S_IDLE | waiting for START, ALU inputs held at 0
// S_LO   | ALU works on low bytes, capture RESULT[7:0] and c
// S_HI   | ALU works on high bytes, capture RESULT[15:8] and CARRY
// S_DONE | DONE pulse, ALU inputs back to 0
module wide_op_seq
    import wide_op_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  CMD,
    input  logic [15:0] OPA_IN,
    input  logic [15:0] OPB_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        CARRY,
    output logic [3:0]  ALU_OP,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic        ALU_SC,
    input  logic [7:0]  ALU_OUT,
    input  logic        ALU_SC_OUT
`ifdef WIDE_OP_OVF_EN
    ,
    output logic        OVF
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  cmd_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] result_q;
    logic        carry_q;
    logic        c_q;       // inter-byte carry; also drives ALU_SC
    logic [3:0]  alu_op_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
`ifdef WIDE_OP_OVF_EN
    logic        ovf_q;
    logic        ovf_d;
`endif

    // ALU drive for the low half, decoded from the live inputs so it can be
    // registered on the accepting edge and be valid throughout LO.
    logic [3:0]  lo_op_d;
    logic [7:0]  lo_a_d;
    logic [7:0]  lo_b_d;

    // ALU drive for the high half, decoded from the latched operands and
    // registered on the LO edge.
    logic [3:0]  hi_op_d;
    logic [7:0]  hi_a_d;
    logic [7:0]  hi_b_d;
    logic        c_d;       // carry passed from the low half into the high half
    logic        carry_d;   // final CARRY captured at the HI edge

    always_comb begin
        lo_op_d = kNOP;
        lo_a_d  = 8'h00;
        lo_b_d  = 8'h00;
        unique case (CMD)
            CMD_ADD: begin
                lo_op_d = kADDL;
                lo_a_d  = OPA_IN[7:0];
                lo_b_d  = OPB_IN[7:0];
            end
            CMD_SLL: begin
                lo_op_d = kSLG;
                lo_b_d  = OPA_IN[7:0];
            end
            CMD_XOR: begin
                lo_op_d = kXOR;
                lo_a_d  = OPA_IN[7:0];
                lo_b_d  = OPB_IN[7:0];
            end
            CMD_NOT: begin
                lo_op_d = kNOT;
                lo_b_d  = OPA_IN[7:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        hi_op_d = kNOP;
        hi_a_d  = 8'h00;
        hi_b_d  = 8'h00;
        c_d     = 1'b0;
        carry_d = 1'b0;
        unique case (cmd_q)
            CMD_ADD: begin
                hi_op_d = kADDL;
                hi_a_d  = opa_q[15:8];
                hi_b_d  = opb_q[15:8];
                c_d     = ALU_SC_OUT;
                carry_d = ALU_SC_OUT;
            end
            CMD_SLL: begin
                hi_op_d = kSLO;
                hi_b_d  = opa_q[15:8];
                c_d     = ALU_SC_OUT;
                // The high-half shift-out is a[15]; take it from the
                // latched operand rather than the ALU.
                carry_d = opa_q[15];
            end
            CMD_XOR: begin
                hi_op_d = kXOR;
                hi_a_d  = opa_q[15:8];
                hi_b_d  = opb_q[15:8];
            end
            CMD_NOT: begin
                hi_op_d = kNOT;
                hi_b_d  = opa_q[15:8];
            end
            default: ;
        endcase
    end

`ifdef WIDE_OP_OVF_EN
    // Signed overflow: operands agree in sign but the sum does not.
    always_comb begin
        ovf_d = 1'b0;
        if (cmd_q == CMD_ADD) begin
            ovf_d = (opa_q[15] == opb_q[15]) && (ALU_OUT[7] != opa_q[15]);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cmd_q    <= 2'b00;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
            c_q      <= 1'b0;
            alu_op_q <= kNOP;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
`ifdef WIDE_OP_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        cmd_q    <= CMD;
                        opa_q    <= OPA_IN;
                        opb_q    <= OPB_IN;
                        busy_q   <= 1'b1;
                        c_q      <= 1'b0;
                        alu_op_q <= lo_op_d;
                        alu_a_q  <= lo_a_d;
                        alu_b_q  <= lo_b_d;
                        state_q  <= S_LO;
                    end
                end
                S_LO: begin
                    result_q[7:0] <= ALU_OUT;
                    c_q           <= c_d;
                    alu_op_q      <= hi_op_d;
                    alu_a_q       <= hi_a_d;
                    alu_b_q       <= hi_b_d;
                    state_q       <= S_HI;
                end
                S_HI: begin
                    result_q[15:8] <= ALU_OUT;
                    carry_q        <= carry_d;
`ifdef WIDE_OP_OVF_EN
                    ovf_q          <= ovf_d;
`endif
                    busy_q         <= 1'b0;
                    done_q         <= 1'b1;
                    c_q            <= 1'b0;
                    alu_op_q       <= kNOP;
                    alu_a_q        <= 8'h00;
                    alu_b_q        <= 8'h00;
                    state_q        <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign CARRY  = carry_q;
    assign ALU_OP = alu_op_q;
    assign ALU_A  = alu_a_q;
    assign ALU_B  = alu_b_q;
    assign ALU_SC = c_q;
`ifdef WIDE_OP_OVF_EN
    assign OVF    = ovf_q;
`endif

endmodule
